pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline flush/stall controller for redirects, load-use hazards and external freezes.
// Optional HAZARD_STATS_EN adds saturating flush_cnt/stall_cnt event counters.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int FLUSH_HOLD  = 0,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  branch_taken,
    input  logic                  jump,
    input  logic                  load_use,
    input  logic                  ext_stall,
    output logic [NUM_STAGES-1:0] flush_vec,
    output logic [NUM_STAGES-1:0] stall_vec,
    output logic                  pc_hold,
    output logic                  busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_LU} state_t;

    localparam logic [NUM_STAGES-1:0] FRONT  = NUM_STAGES'((1 << FLUSH_DEPTH) - 1);
    localparam logic [NUM_STAGES-1:0] HOLD   = NUM_STAGES'(3);
    localparam logic [NUM_STAGES-1:0] BUBBLE = NUM_STAGES >= 3 ? NUM_STAGES'(4) : '0;

    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES - 1 || FLUSH_HOLD < 0 || FLUSH_HOLD > 15 || CNT_W < 1) begin : g_bad_params
        $error("pipe_hazard_ctrl: illegal parameter combination");
    end

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_redirect, w_redir_acc, w_lu_stall, w_flush_on, w_freeze;

    // LU_STALL has a bubble in EX, so nothing there can resolve a redirect
    assign w_redirect  = branch_taken | jump;
    assign w_redir_acc = !ext_stall && w_redirect && r_state != S_LU;
    assign w_lu_stall  = rst_n && !ext_stall && !w_redirect && load_use && r_state == S_IDLE;
    assign w_flush_on  = rst_n && !ext_stall && (r_state == S_FLUSH || (r_state == S_IDLE && w_redirect));
    assign w_freeze    = rst_n && ext_stall;

    assign flush_vec = (w_flush_on ? FRONT : '0) | (w_lu_stall ? BUBBLE : '0);
    assign stall_vec = w_freeze ? '1 : (w_lu_stall ? HOLD : '0);
    assign pc_hold   = w_freeze | w_lu_stall;
    assign busy      = r_state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (!ext_stall) begin
            if (w_redir_acc) begin
                r_cnt   <= 4'(FLUSH_HOLD);
                r_state <= FLUSH_HOLD > 0 ? S_FLUSH : S_IDLE;
            end else if (r_state == S_FLUSH) begin
                r_cnt   <= r_cnt - 4'd1;
                r_state <= r_cnt == 4'd1 ? S_IDLE : S_FLUSH;
            end else if (w_lu_stall) begin
                r_state <= S_LU;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_flush_cnt, r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_redir_acc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_lu_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign flush_cnt = r_flush_cnt;
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a cycle-level hazard model and randomized stimulus.
module tb_pipe_hazard_ctrl;
    localparam int NS = 5, FD = 2, FH = 2, CW = 2;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [NS-1:0] FRONT = NS'((1 << FD) - 1);

    logic clk = 0, rst_n = 0, bt = 0, jp = 0, lu = 0, es = 0;
    logic [NS-1:0] fv, sv;
    logic ph, bz;
    logic [CW-1:0] fc, sc;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NUM_STAGES(NS), .FLUSH_DEPTH(FD), .FLUSH_HOLD(FH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .branch_taken(bt), .jump(jp), .load_use(lu), .ext_stall(es),
        .flush_vec(fv), .stall_vec(sv), .pc_hold(ph), .busy(bz)
`ifdef HAZARD_STATS_EN
        , .flush_cnt(fc), .stall_cnt(sc)
`endif
    );
`ifndef HAZARD_STATS_EN
    assign fc = '0;
    assign sc = '0;
`endif

    typedef struct {
        logic [NS-1:0] fv, sv;
        logic ph, bz;
        int fc, sc;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;
    int m_left = 0, m_fc = 0, m_sc = 0;
    bit m_lu = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock of stimulus; the model tracks remaining hold cycles and a pending bubble
    task automatic step(input logic b, input logic j, input logic l, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        bt = b; jp = j; lu = l; es = e;
        x.fv = '0; x.sv = '0; x.ph = 0;
        x.bz = (m_left > 0) || m_lu;
        x.fc = m_fc; x.sc = m_sc;
        if (e) begin
            x.sv = '1; x.ph = 1;
        end else if (m_lu) begin
            m_lu = 0;
        end else if (b | j) begin
            x.fv = FRONT; m_left = FH;
            if (m_fc < MAXC) m_fc++;
        end else if (m_left > 0) begin
            x.fv = FRONT; m_left--;
        end else if (l) begin
            x.sv = NS'(3); x.fv = NS'(4); x.ph = 1; m_lu = 1;
            if (m_sc < MAXC) m_sc++;
        end
        q.push_back(x);
    endtask

    task automatic idle_outs(input string nm);
        chk({nm, "_fv"}, 32'(fv), 0);
        chk({nm, "_sv"}, 32'(sv), 0);
        chk({nm, "_ph"}, 32'(ph), 0);
        chk({nm, "_bz"}, 32'(bz), 0);
`ifdef HAZARD_STATS_EN
        chk({nm, "_fc"}, 32'(fc), 0);
        chk({nm, "_sc"}, 32'(sc), 0);
`endif
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("flush_vec", 32'(fv), 32'(x.fv));
                chk("stall_vec", 32'(sv), 32'(x.sv));
                chk("pc_hold", 32'(ph), 32'(x.ph));
                chk("busy", 32'(bz), 32'(x.bz));
`ifdef HAZARD_STATS_EN
                chk("flush_cnt", 32'(fc), 32'(x.fc));
                chk("stall_cnt", 32'(sc), 32'(x.sc));
`endif
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        idle_outs("reset");
        #2 rst_n = 1;
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        repeat (5) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        repeat (4) step(0, 0, 0, 0);
        for (int i = 0; i < 1500; i++)
            step($urandom % 8 == 0, $urandom % 12 == 0, $urandom % 3 == 0, $urandom % 7 == 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        @(posedge clk);
        #1;
        bt = 0; jp = 0; lu = 0; es = 0;
        chk("pre_rst_flush", 32'(fv), 32'(FRONT));
        #2;
        rst_n = 0;
        bt = 1;
        #1;
        idle_outs("async_rst");
        @(posedge clk);
        #2;
        idle_outs("in_rst");
        bt = 0;
        #2 rst_n = 1;
        m_left = 0; m_lu = 0; m_fc = 0; m_sc = 0;
        step(0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
